cmd_source_arbiter: RTL and testbench

CMD_SOURCE_ARBITER -- requirements
Module: cmd_source_arbiter

---
 rtl/cmd_source_arbiter.sv | 141 ++++++++++++++
 tb/tb_cmd_source_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_source_arbiter.sv
// cmd_source_arbiter: hands the control unit to one of two command sources for a whole command.
// Define CMD_ARB_TIMEOUT_EN to build the idle watchdog that aborts stalled commands.
module cmd_source_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned PRIORITY_MODE  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0][7:0] src_byte,
  input  logic [1:0]      src_ready,
  output logic [1:0]      src_next,
  output logic [7:0]      ctrl_in_byte,
  output logic            ctrl_in_ready,
  input  logic            ctrl_next,
  input  logic            ctrl_ready,
  output logic            grant,
  output logic            grant_valid,
  output logic            abort,
  output logic [15:0]     cmd_count,
  output logic [7:0]      timeout_count
);

  typedef enum logic [1:0] {StIdle, StActive, StRelease} state_e;

  state_e      state_q;
  logic        grant_q;
  logic        last_grant_q;
  logic        grant_valid_q;
  logic        seen_busy_q;
  logic [15:0] cmd_count_q;

  logic winner;
  logic next_ok;
  logic complete;
  logic expire;

  always_comb begin
    winner = 1'b0;
    if (PRIORITY_MODE == 1) begin
      winner = ~src_ready[0];
    end else if (src_ready == 2'b11) begin
      winner = ~last_grant_q;
    end else begin
      winner = src_ready[1];
    end
  end

  // A consumed byte only counts while a source actually owns the control unit.
  assign next_ok  = ctrl_next & grant_valid_q;
  // The control unit went busy on this command and has come back to READY.
  assign complete = (state_q == StActive) && ctrl_ready && seen_busy_q;

`ifdef CMD_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WdW-1:0] watchdog_q;
  logic           abort_q;
  logic [7:0]     timeout_count_q;

  // Expiry is the edge on which the watchdog would reach TIMEOUT_CYCLES-1; completion wins.
  assign expire = (state_q == StActive) && !complete && !next_ok &&
                  (watchdog_q == WdW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      watchdog_q      <= '0;
      abort_q         <= 1'b0;
      timeout_count_q <= '0;
    end else begin
      abort_q <= expire;
      if (expire && (timeout_count_q != 8'hFF)) begin
        timeout_count_q <= timeout_count_q + 8'd1;
      end
      if ((state_q != StActive) || next_ok) begin
        watchdog_q <= '0;
      end else begin
        watchdog_q <= watchdog_q + WdW'(1);
      end
    end
  end

  assign abort         = abort_q;
  assign timeout_count = timeout_count_q;
`else
  assign expire        = 1'b0;
  assign abort         = 1'b0;
  assign timeout_count = 8'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      grant_valid_q <= 1'b0;
      seen_busy_q   <= 1'b0;
      cmd_count_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_ready && (src_ready != 2'b00)) begin
            grant_q       <= winner;
            grant_valid_q <= 1'b1;
            seen_busy_q   <= 1'b0;
            state_q       <= StActive;
          end
        end
        StActive: begin
          if (complete) begin
            grant_valid_q <= 1'b0;
            cmd_count_q   <= cmd_count_q + 16'd1;
            state_q       <= StRelease;
          end else if (expire) begin
            grant_valid_q <= 1'b0;
            state_q       <= StIdle;
          end else if (!ctrl_ready) begin
            seen_busy_q <= 1'b1;
          end
        end
        StRelease: begin
          last_grant_q <= grant_q;
          seen_busy_q  <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    src_next          = 2'b00;
    src_next[grant_q] = next_ok;
  end

  assign ctrl_in_byte  = src_byte[grant_q];
  assign ctrl_in_ready = src_ready[grant_q] & grant_valid_q;
  assign grant         = grant_q;
  assign grant_valid   = grant_valid_q;
  assign cmd_count     = cmd_count_q;

endmodule

// File: tb/tb_cmd_source_arbiter.sv
// Bench for cmd_source_arbiter: round-robin and fixed-priority instances share one stimulus
// stream and are checked every cycle against a command-level model, plus directed scenarios.
module tb_cmd_source_arbiter;

  localparam int unsigned T = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0][7:0] src_byte = '0;
  logic [1:0]      src_ready = '0;
  logic            ctrl_next = 1'b0;
  logic            ctrl_ready = 1'b0;

  logic [1:0]  o_next  [2];
  logic [7:0]  o_byte  [2];
  logic        o_rdy   [2];
  logic        o_grant [2];
  logic        o_gv    [2];
  logic        o_abort [2];
  logic [15:0] o_cmd   [2];
  logic [7:0]  o_to    [2];

  int compared = 0;
  int mismatched = 0;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  int m_act[2], m_rel[2], m_last[2], m_grant[2], m_busy[2];
  int m_cmd[2], m_to[2], m_wd[2], m_abort[2];
  int pulses[2][2];
  string names[2] = '{"rr", "fp"};

  always #5 clk = ~clk;

  cmd_source_arbiter #(.TIMEOUT_CYCLES(T), .PRIORITY_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .src_byte(src_byte), .src_ready(src_ready),
    .src_next(o_next[0]), .ctrl_in_byte(o_byte[0]), .ctrl_in_ready(o_rdy[0]),
    .ctrl_next(ctrl_next), .ctrl_ready(ctrl_ready), .grant(o_grant[0]),
    .grant_valid(o_gv[0]), .abort(o_abort[0]), .cmd_count(o_cmd[0]),
    .timeout_count(o_to[0])
  );

  cmd_source_arbiter #(.TIMEOUT_CYCLES(T), .PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .src_byte(src_byte), .src_ready(src_ready),
    .src_next(o_next[1]), .ctrl_in_byte(o_byte[1]), .ctrl_in_ready(o_rdy[1]),
    .ctrl_next(ctrl_next), .ctrl_ready(ctrl_ready), .grant(o_grant[1]),
    .grant_valid(o_gv[1]), .abort(o_abort[1]), .cmd_count(o_cmd[1]),
    .timeout_count(o_to[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_act[m] = 0; m_rel[m] = 0; m_last[m] = 1; m_grant[m] = 0; m_busy[m] = 0;
      m_cmd[m] = 0; m_to[m] = 0; m_wd[m] = 0; m_abort[m] = 0;
    end
  endtask

  task automatic clear_pulses();
    for (int m = 0; m < 2; m++) begin
      pulses[m][0] = 0;
      pulses[m][1] = 0;
    end
  endtask

  // One clock edge worth of command-level behaviour for instance m.
  task automatic model_step(input int m);
    int w;
    m_abort[m] = 0;
    if (m_rel[m] != 0) begin
      m_last[m] = m_grant[m];
      m_rel[m]  = 0;
    end else if (m_act[m] == 0) begin
      if (ctrl_ready && (src_ready != 2'b00)) begin
        if (m == 1)                   w = src_ready[0] ? 0 : 1;
        else if (src_ready == 2'b11) w = 1 - m_last[m];
        else                          w = src_ready[1] ? 1 : 0;
        m_grant[m] = w; m_act[m] = 1; m_busy[m] = 0; m_wd[m] = 0;
      end
    end else if (ctrl_ready && (m_busy[m] != 0)) begin
      m_act[m] = 0;
      m_rel[m] = 1;
      m_cmd[m] = (m_cmd[m] + 1) % 65536;
    end else begin
`ifdef CMD_ARB_TIMEOUT_EN
      if (ctrl_next) begin
        m_wd[m] = 0;
      end else if (m_wd[m] + 1 == int'(T) - 1) begin
        m_abort[m] = 1;
        if (m_to[m] < 255) m_to[m]++;
        m_act[m] = 0;
      end else begin
        m_wd[m]++;
      end
`endif
      if (!ctrl_ready) m_busy[m] = 1;
    end
  endtask

  // Compare both instances mid-cycle, then advance the models on the edge.
  task automatic cycle();
    int en;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      en = m_act[m] != 0 ? 1 : 0;
      check({names[m], ".grant_valid"}, 32'(o_gv[m]), en);
      check({names[m], ".grant"}, 32'(o_grant[m]), m_grant[m]);
      check({names[m], ".ctrl_in_byte"}, 32'(o_byte[m]), 32'(src_byte[m_grant[m]]));
      check({names[m], ".ctrl_in_ready"}, 32'(o_rdy[m]),
            (en != 0 && src_ready[m_grant[m]]) ? 1 : 0);
      check({names[m], ".src_next"}, 32'(o_next[m]),
            (en != 0 && ctrl_next) ? (1 << m_grant[m]) : 0);
      check({names[m], ".abort"}, 32'(o_abort[m]), m_abort[m]);
      check({names[m], ".cmd_count"}, 32'(o_cmd[m]), m_cmd[m]);
      check({names[m], ".timeout_count"}, 32'(o_to[m]), m_to[m]);
      if (o_next[m][0]) pulses[m][0]++;
      if (o_next[m][1]) pulses[m][1]++;
    end
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_ready = 2'b00; ctrl_next = 1'b0; ctrl_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes [4];
    int at;
    bytes = '{8'h10, 8'h03, 8'h00, 8'h05};

    // Single source command with the control unit going busy after the first byte.
    do_reset();
    clear_pulses();
    src_byte[1] = 8'hEE; src_byte[0] = bytes[0]; src_ready = 2'b01;
    cycle();
    cycle();  // checks reset-state outputs of the now-granted cycle via the model
    for (int i = 1; i < 4; i++) begin
      src_byte[0] = bytes[i];
      ctrl_next = 1'b1; ctrl_ready = (i == 1);
      cycle();
    end
    src_byte[0] = bytes[0]; ctrl_next = 1'b1; ctrl_ready = 1'b0;
    cycle();
    ctrl_next = 1'b0; ctrl_ready = 1'b1; src_ready = 2'b00;
    cycle();
    check("single.release_gv", 32'(o_gv[0]), 0);
    cycle();
    cycle();
    check("single.src0_pulses", pulses[0][0], 4);
    check("single.src1_pulses", pulses[0][1], 0);
    check("single.cmd_count", 32'(o_cmd[0]), 1);

    // Contention: round-robin alternates 0,1,0; fixed priority always source 0.
    do_reset();
    clear_pulses();
    src_ready = 2'b11; src_byte[0] = 8'hA0; src_byte[1] = 8'hB1;
    for (int k = 0; k < 3; k++) begin
      ctrl_ready = 1'b1; ctrl_next = 1'b0;
      cycle();
      check("rr.contention_grant", 32'(o_grant[0]), k % 2);
      check("fp.contention_grant", 32'(o_grant[1]), 0);
      ctrl_next = 1'b1; ctrl_ready = 1'b0;
      cycle();
      ctrl_next = 1'b0; ctrl_ready = 1'b1;
      cycle();
      cycle();
    end
    check("fp.src1_pulses", pulses[1][1], 0);
    check("fp.src0_pulses", pulses[1][0], 3);
    check("rr.cmd_count3", 32'(o_cmd[0]), 3);

    // Reset in the middle of a command takes effect with no clock edge.
    src_ready = 2'b01; ctrl_ready = 1'b1; ctrl_next = 1'b0;
    cycle();
    ctrl_next = 1'b1; ctrl_ready = 1'b0;
    cycle();
    cycle();
    #2 reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check({names[m], ".rst_gv"}, 32'(o_gv[m]), 0);
      check({names[m], ".rst_in_ready"}, 32'(o_rdy[m]), 0);
      check({names[m], ".rst_src_next"}, 32'(o_next[m]), 0);
      check({names[m], ".rst_cmd"}, 32'(o_cmd[m]), 0);
      check({names[m], ".rst_to"}, 32'(o_to[m]), 0);
      check({names[m], ".rst_abort"}, 32'(o_abort[m]), 0);
    end
    do_reset();
    src_ready = 2'b11; ctrl_ready = 1'b1;
    cycle();
    check("rr.post_reset_grant", 32'(o_grant[0]), 0);
    ctrl_next = 1'b1; ctrl_ready = 1'b0;
    cycle();
    ctrl_next = 1'b0; ctrl_ready = 1'b1;
    cycle();
    cycle();

    // Source 1 stalls after one byte.
    do_reset();
    src_ready = 2'b10; ctrl_ready = 1'b1;
    cycle();
    ctrl_next = 1'b1; ctrl_ready = 1'b0;
    cycle();
    ctrl_next = 1'b0; src_ready = 2'b00;
    at = -1;
    for (int i = 1; i <= 40; i++) begin
      if (o_abort[0] && at < 0) at = i;
      cycle();
    end
`ifdef CMD_ARB_TIMEOUT_EN
    check("stall.abort_cycle", at, 16);
    check("stall.timeout_count", 32'(o_to[0]), 1);
    check("stall.cmd_count", 32'(o_cmd[0]), 0);
    check("stall.gv", 32'(o_gv[0]), 0);

    // Completion on the same edge as expiry.
    do_reset();
    src_ready = 2'b01; ctrl_ready = 1'b1;
    cycle();
    ctrl_next = 1'b1; ctrl_ready = 1'b0;
    cycle();
    ctrl_next = 1'b0;
    for (int i = 1; i < 15; i++) cycle();
    ctrl_ready = 1'b1;
    cycle();
    check("coincide.abort", 32'(o_abort[0]), 0);
    check("coincide.cmd_count", 32'(o_cmd[0]), 1);
    cycle();
    cycle();
`else
    check("stall.no_abort", at, -1);
    check("stall.still_granted", 32'(o_gv[0]), 1);
`endif

    // Random traffic, alternating busy and quiet control-unit phases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      src_ready   = 2'($urandom);
      src_byte[0] = 8'($urandom);
      src_byte[1] = 8'($urandom);
      if (((i / 200) % 2) == 1) ctrl_next = ($urandom_range(23) == 0);
      else                      ctrl_next = 1'($urandom);
      ctrl_ready = ($urandom_range(2) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
